// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: FSM states, default NRZ timing at 50 MHz, pixel word geometry.
package ws2812_pkg;

   localparam int PIX_WORD_W    = 24;
   localparam int PIXEL_NUM_DEF = 64;
   localparam int BIT_CYC_DEF   = 63;
   localparam int T0H_CYC_DEF   = 20;
   localparam int T1H_CYC_DEF   = 40;
   localparam int RST_CYC_DEF   = 15000;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      RST
   } tx_state_t;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ws2812_tx_ctrl_if.sv
// Pixel fetch handshake between the config block (master) and the WS2812 transmitter (slave).
interface ws2812_tx_ctrl_if;
   import ws2812_pkg::*;

   logic                  ws2812_start;
   logic [PIX_WORD_W-1:0] cfg_data;
   logic                  cfg_start;

   modport master (output ws2812_start, output cfg_data, input cfg_start);
   modport slave  (input ws2812_start, input cfg_data, output cfg_start);

endinterface

// File: rtl/ws2812_bit_gen.sv
// NRZ line encoder: drives the data pin high for T0H/T1H clocks at the start of each bit period.
module ws2812_bit_gen #(
   parameter int T0H_CYC = 20,
   parameter int T1H_CYC = 40,
   parameter int CYC_W   = 6
)(
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             i_en,
   input  logic [CYC_W-1:0] i_cyc_cnt,
   input  logic             i_bit,
   output logic             o_dout
);

   localparam logic [CYC_W-1:0] T0H_L = CYC_W'(T0H_CYC);
   localparam logic [CYC_W-1:0] T1H_L = CYC_W'(T1H_CYC);

   logic r_dout;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_dout <= 1'b0;
      end else begin
         r_dout <= i_en && (i_cyc_cnt < (i_bit ? T1H_L : T0H_L));
      end
   end

   assign o_dout = r_dout;

endmodule

// File: rtl/ws2812_tx_ctrl.sv
// WS2812 frame transmitter: fetches PIXEL_NUM GRB words, sends them MSB first, then a latch gap.
// Optional WS2812_FRAME_DONE_EN adds a frame_done pulse on the cycle the latch gap ends.
module ws2812_tx_ctrl
   import ws2812_pkg::*;
#(
   parameter int PIXEL_NUM = PIXEL_NUM_DEF,
   parameter int BIT_CYC   = BIT_CYC_DEF,
   parameter int T0H_CYC   = T0H_CYC_DEF,
   parameter int T1H_CYC   = T1H_CYC_DEF,
   parameter int RST_CYC   = RST_CYC_DEF
)(
   input  logic            sys_clk,
   input  logic            sys_rst_n,
   ws2812_tx_ctrl_if.slave cfg_bus,
   output logic            dout
`ifdef WS2812_FRAME_DONE_EN
   ,
   output logic            frame_done
`endif
);

   localparam int CYC_W  = cnt_w(BIT_CYC);
   localparam int BIT_W  = cnt_w(PIX_WORD_W);
   localparam int PIX_W  = cnt_w(PIXEL_NUM);
   localparam int RSTC_W = cnt_w(RST_CYC);

   localparam logic [CYC_W-1:0]  CYC_LAST = CYC_W'(BIT_CYC - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(PIX_WORD_W - 1);
   localparam logic [PIX_W-1:0]  PIX_LAST = PIX_W'(PIXEL_NUM - 1);
   localparam logic [RSTC_W-1:0] RST_LAST = RSTC_W'(RST_CYC - 1);

   tx_state_t             r_state;
   logic [PIX_WORD_W-1:0] r_shift_reg;
   logic [CYC_W-1:0]      r_cyc_cnt;
   logic [BIT_W-1:0]      r_bit_cnt;
   logic [PIX_W-1:0]      r_pix_cnt;
   logic [RSTC_W-1:0]     r_rst_cnt;
   logic                  r_rst_done;
   logic                  r_start_pend;
   logic                  r_cfg_start;
   logic                  r_frame_done;

   logic w_start_req;
   logic w_bit_end;
   logic w_send_en;
   logic w_dout;

   assign w_start_req = cfg_bus.ws2812_start | r_start_pend;
   assign w_bit_end   = (r_cyc_cnt == CYC_LAST);
   assign w_send_en   = (r_state == SEND);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state      <= IDLE;
         r_shift_reg  <= '0;
         r_cyc_cnt    <= '0;
         r_bit_cnt    <= '0;
         r_pix_cnt    <= '0;
         r_rst_cnt    <= '0;
         r_rst_done   <= 1'b0;
         r_start_pend <= 1'b0;
         r_cfg_start  <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_cfg_start  <= 1'b0;
         r_frame_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_start_req) begin
                  r_shift_reg  <= cfg_bus.cfg_data;
                  r_cfg_start  <= 1'b1;
                  r_bit_cnt    <= '0;
                  r_cyc_cnt    <= '0;
                  r_pix_cnt    <= '0;
                  r_start_pend <= 1'b0;
                  r_state      <= SEND;
               end
            end
            SEND: begin
               if (cfg_bus.ws2812_start) r_start_pend <= 1'b1;
               if (!w_bit_end) begin
                  r_cyc_cnt <= r_cyc_cnt + 1'b1;
               end else if (r_bit_cnt != BIT_LAST) begin
                  r_shift_reg <= {r_shift_reg[PIX_WORD_W-2:0], 1'b0};
                  r_bit_cnt   <= r_bit_cnt + 1'b1;
                  r_cyc_cnt   <= '0;
               end else if (r_pix_cnt != PIX_LAST) begin
                  r_shift_reg <= cfg_bus.cfg_data;
                  r_cfg_start <= 1'b1;
                  r_bit_cnt   <= '0;
                  r_cyc_cnt   <= '0;
                  r_pix_cnt   <= r_pix_cnt + 1'b1;
               end else begin
                  r_cyc_cnt  <= '0;
                  r_rst_cnt  <= '0;
                  r_rst_done <= 1'b0;
                  r_state    <= RST;
               end
            end
            RST: begin
               // The gap runs RST_CYC counted cycles plus the exit cycle, where a start is taken directly.
               if (!r_rst_done) begin
                  if (cfg_bus.ws2812_start) r_start_pend <= 1'b1;
                  if (r_rst_cnt == RST_LAST) r_rst_done <= 1'b1;
                  else                       r_rst_cnt  <= r_rst_cnt + 1'b1;
               end else begin
                  r_rst_done   <= 1'b0;
                  r_frame_done <= 1'b1;
                  if (w_start_req) begin
                     r_shift_reg  <= cfg_bus.cfg_data;
                     r_cfg_start  <= 1'b1;
                     r_bit_cnt    <= '0;
                     r_cyc_cnt    <= '0;
                     r_pix_cnt    <= '0;
                     r_start_pend <= 1'b0;
                     r_state      <= SEND;
                  end else begin
                     r_state <= IDLE;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   ws2812_bit_gen #(
      .T0H_CYC (T0H_CYC),
      .T1H_CYC (T1H_CYC),
      .CYC_W   (CYC_W)
   ) u_bit_gen (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .i_en      (w_send_en),
      .i_cyc_cnt (r_cyc_cnt),
      .i_bit     (r_shift_reg[PIX_WORD_W-1]),
      .o_dout    (w_dout)
   );

   assign dout              = w_dout;
   assign cfg_bus.cfg_start = r_cfg_start;

`ifdef WS2812_FRAME_DONE_EN
   assign frame_done = r_frame_done;
`else
   logic w_frame_done_unused;
   assign w_frame_done_unused = r_frame_done;
`endif

endmodule

// File: tb/tb_ws2812_tx_ctrl.sv
// Scoreboard bench for ws2812_tx_ctrl with a small frame (2 pixels) and shortened latch gap.
module tb_ws2812_tx_ctrl;
   import ws2812_pkg::*;

   localparam int PIX    = 2;
   localparam int BITC   = 63;
   localparam int T0H    = 20;
   localparam int T1H    = 40;
   localparam int RSTC   = 1500;
   localparam int PIXPER = 24 * BITC;
   localparam int FRAME  = PIX * PIXPER;
   localparam int PERIOD = FRAME + RSTC + 1;

   logic sys_clk   = 1'b0;
   logic sys_rst_n = 1'b0;
   logic dout;
   logic man_start  = 1'b0;
   logic auto_start = 1'b0;
   bit   fixed_data = 1'b1;
   bit   cont_mode  = 1'b0;
`ifdef WS2812_FRAME_DONE_EN
   logic frame_done;
`endif

   int   cycle    = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   int   n_bits   = 0;
   int   n_fd     = 0;
   int   pix_idx  = 0;
   int   h_run    = 0;
   int   l_run    = 0;
   int   prev_h   = 0;
   logic exp_q[$];
   int   fetch_q[$];

   ws2812_tx_ctrl_if bus();
   assign bus.ws2812_start = man_start | auto_start;

   ws2812_tx_ctrl #(
      .PIXEL_NUM (PIX),
      .BIT_CYC   (BITC),
      .T0H_CYC   (T0H),
      .T1H_CYC   (T1H),
      .RST_CYC   (RSTC)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .cfg_bus   (bus),
      .dout      (dout)
`ifdef WS2812_FRAME_DONE_EN
      ,
      .frame_done(frame_done)
`endif
   );

   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cycle++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cycle);
      end
   endtask

   // Config block model: serves pixel words, records expected bits on each fetch.
   always @(negedge sys_clk) begin
      auto_start = 1'b0;
      if (!sys_rst_n) begin
         pix_idx      = 0;
         bus.cfg_data = fixed_data ? 24'hFF00AA : 24'($urandom);
      end else begin
         if (bus.cfg_start) begin
            for (int i = 23; i >= 0; i--) exp_q.push_back(bus.cfg_data[i]);
            fetch_q.push_back(cycle);
            pix_idx      = (pix_idx + 1) % PIX;
            bus.cfg_data = fixed_data ? 24'hFF00AA : 24'($urandom);
            if (cont_mode && pix_idx == 0) auto_start = 1'b1;
         end
`ifdef WS2812_FRAME_DONE_EN
         if (frame_done) begin
            n_fd++;
            if (cont_mode) check("fd_with_fetch", bus.cfg_start, 1);
         end
`endif
      end
   end

   // Line monitor: decodes each high pulse into a bit and checks pulse/period widths.
   always @(negedge sys_clk) begin
      logic eb;
      if (!sys_rst_n) begin
         h_run  = 0;
         l_run  = 0;
         prev_h = 0;
      end else if (dout) begin
         if (l_run > 0 && prev_h > 0 && l_run < BITC) check("bit_period", prev_h + l_run, BITC);
         l_run = 0;
         h_run++;
      end else begin
         if (h_run > 0) begin
            if (exp_q.size() == 0) begin
               check("bit_unexpected", h_run, 0);
            end else begin
               eb = exp_q.pop_front();
               check("bit_high", h_run, eb ? T1H : T0H);
               n_bits++;
            end
            prev_h = h_run;
            h_run  = 0;
         end
         l_run++;
      end
   end

   task automatic wait_fetch(input int n, input int budget, input string tag);
      int k = 0;
      while (fetch_q.size() < n && k < budget) begin
         @(negedge sys_clk);
         k++;
      end
      check(tag, fetch_q.size() >= n, 1);
   endtask

   task automatic wait_cycle(input int c);
      while (cycle < c) @(negedge sys_clk);
   endtask

   task automatic pulse_at(input int c);
      while (cycle < c - 1) @(negedge sys_clk);
      man_start = 1'b1;
      @(negedge sys_clk);
      man_start = 1'b0;
   endtask

   task automatic pulse_now();
      @(negedge sys_clk);
      man_start = 1'b1;
      @(negedge sys_clk);
      man_start = 1'b0;
   endtask

   initial begin
      #(100000 * 10);
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int b0;
      int t0;
      int k;

      // Reset state
      repeat (3) @(negedge sys_clk);
      check("rst_dout", dout, 0);
      check("rst_cfg_start", bus.cfg_start, 0);
      sys_rst_n = 1'b1;
      repeat (5) @(negedge sys_clk);
      check("idle_dout", dout, 0);
      check("idle_no_fetch", fetch_q.size(), 0);

      // Single fixed-pattern frame with start latency
      b0 = n_bits;
      @(negedge sys_clk);
      man_start = 1'b1;
      @(posedge sys_clk);
      #1;
      check("lat_fetch", bus.cfg_start, 1);
      check("lat_dout_low", dout, 0);
      @(negedge sys_clk);
      man_start = 1'b0;
      @(posedge sys_clk);
      #1;
      check("lat_rise", dout, 1);
      wait_fetch(2, 2 * FRAME, "f1_fetch");
      check("f1_fetch_spacing", fetch_q[1] - fetch_q[0], PIXPER);
      wait_cycle(fetch_q[0] + PERIOD + 200);
      check("f1_bits", n_bits - b0, 48);
      check("f1_sb_empty", exp_q.size(), 0);
      check("f1_fetches", fetch_q.size(), 2);
      check("f1_gap_low", l_run >= RSTC + 200, 1);

      // Queued start: one pulse mid-frame, two in the latch gap -> exactly one extra frame
      fixed_data = 1'b0;
      fetch_q.delete();
      b0 = n_bits;
      pulse_now();
      wait_fetch(1, 10, "q_first");
      t0 = fetch_q[0];
      pulse_at(t0 + PIXPER + 700);
      pulse_at(t0 + FRAME + 100);
      pulse_at(t0 + FRAME + 900);
      wait_fetch(3, PERIOD, "q_second");
      check("q_restart", fetch_q[2] - t0, PERIOD);
      wait_cycle(t0 + 2 * PERIOD + 1000);
      check("q_no_third", fetch_q.size(), 4);
      check("q_bits", n_bits - b0, 96);
      check("q_sb_empty", exp_q.size(), 0);

      // Async reset mid-bit, then a clean frame
      fetch_q.delete();
      pulse_now();
      k = 0;
      while (!dout && k < 5) begin
         @(negedge sys_clk);
         k++;
      end
      check("pre_rst_high", dout, 1);
      repeat (4) @(negedge sys_clk);
      #2;
      sys_rst_n = 1'b0;
      #1;
      check("async_dout", dout, 0);
      check("async_cfg_start", bus.cfg_start, 0);
      repeat (3) @(negedge sys_clk);
      exp_q.delete();
      fetch_q.delete();
      sys_rst_n = 1'b1;
      repeat (5) @(negedge sys_clk);
      b0 = n_bits;
      pulse_now();
      wait_fetch(2, 2 * FRAME, "ar_fetch");
      t0 = fetch_q[0];
      wait_cycle(t0 + PERIOD + 200);
      check("ar_bits", n_bits - b0, 48);
      check("ar_sb_empty", exp_q.size(), 0);
      check("ar_fetches", fetch_q.size(), 2);

      // Continuous refresh driven by the config model's own start after its last fetch
      fetch_q.delete();
      b0 = n_bits;
      cont_mode = 1'b1;
      pulse_now();
      wait_fetch(7, 4 * PERIOD, "cont_fetch");
      cont_mode = 1'b0;
      for (int f = 1; f <= 3; f++) check("cont_period", fetch_q[2*f] - fetch_q[2*f-2], PERIOD);
      for (int f = 0; f <= 2; f++) check("cont_pix_spacing", fetch_q[2*f+1] - fetch_q[2*f], PIXPER);
      wait_cycle(fetch_q[6] + PERIOD + 500);
      check("cont_fetches", fetch_q.size(), 8);
      check("cont_bits", n_bits - b0, 8 * 24);
      check("cont_sb_empty", exp_q.size(), 0);

`ifdef WS2812_FRAME_DONE_EN
      check("fd_count", n_fd, 8);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
